// File: rtl/mux_pipe_stage.sv
// N-way select into a 2-entry skid buffer; 1-cycle latency, full throughput.
// Backpressure: in_ready is registered (!skid valid), no combinational path from out_ready.
module mux_pipe_stage #(
  parameter  int WIDTH  = 32,
  parameter  int INPUTS = 4,
  localparam int SEL_W  = $clog2(INPUTS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [INPUTS*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    sel_err,
  input  logic                    flush,
  output logic [1:0]              count
);

  typedef struct packed {
    logic             err;
    logic [WIDTH-1:0] dat;
  } entry_t;

  entry_t main_q, skid_q, sel_ent;
  logic   main_vld, skid_vld;
  logic   in_xfer, out_xfer;

  // Out-of-range selects capture zero data tagged with err.
  always_comb begin
    sel_ent.err = 1'b1;
    sel_ent.dat = '0;
    for (int k = 0; k < INPUTS; k++) begin
      if (int'(sel) == k) begin
        sel_ent.err = 1'b0;
        sel_ent.dat = in_data[k*WIDTH +: WIDTH];
      end
    end
  end

  assign in_ready  = !skid_vld;
  assign in_xfer   = in_valid && !skid_vld;
  assign out_xfer  = main_vld && out_ready;
  assign out_valid = main_vld;
  assign out_data  = main_q.dat;
  assign sel_err   = main_q.err;
  assign count     = {1'b0, main_vld} + {1'b0, skid_vld};

  always_ff @(posedge clk) begin
    if (rst) begin
      main_vld <= 1'b0;
      skid_vld <= 1'b0;
      main_q   <= '0;
      skid_q   <= '0;
    end else if (flush) begin
      // Data registers are left as-is; only occupancy is discarded.
      main_vld <= 1'b0;
      skid_vld <= 1'b0;
    end else if (skid_vld) begin
      if (out_xfer) begin
        main_q   <= skid_q;
        skid_vld <= 1'b0;
      end
    end else if (!main_vld || out_xfer) begin
      main_vld <= in_xfer;
      if (in_xfer) main_q <= sel_ent;
    end else if (in_xfer) begin
      skid_vld <= 1'b1;
      skid_q   <= sel_ent;
    end
  end

endmodule

// File: tb/tb_mux_pipe_stage.sv
// Directed vectors against a 4-input and a 3-input instance driven in lockstep.
module tb_mux_pipe_stage;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [1:0]  sel;
  logic [127:0] in_data4;
  logic [95:0]  in_data3;

  logic        in_ready4, out_valid4, sel_err4;
  logic [31:0] out_data4;
  logic [1:0]  count4;
  logic        in_ready3, out_valid3, sel_err3;
  logic [31:0] out_data3;
  logic [1:0]  count3;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mux_pipe_stage #(.WIDTH(32), .INPUTS(4)) dut4 (
    .clk(clk), .rst(rst), .in_data(in_data4), .sel(sel), .in_valid(in_valid),
    .in_ready(in_ready4), .out_data(out_data4), .out_valid(out_valid4),
    .out_ready(out_ready), .sel_err(sel_err4), .flush(flush), .count(count4)
  );

  mux_pipe_stage #(.WIDTH(32), .INPUTS(3)) dut3 (
    .clk(clk), .rst(rst), .in_data(in_data3), .sel(sel), .in_valid(in_valid),
    .in_ready(in_ready3), .out_data(out_data3), .out_valid(out_valid3),
    .out_ready(out_ready), .sel_err(sel_err3), .flush(flush), .count(count3)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    in_data4  = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    in_data3  = {32'h33333333, 32'h22222222, 32'h11111111};
    rst = 1'b1; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b1; sel = 2'd0;

    // Reset held two cycles with an input offered.
    tick(); tick();
    chk("rst_out_valid", {31'd0, out_valid4}, 32'd0);
    chk("rst_out_data",  out_data4, 32'd0);
    chk("rst_count",     {30'd0, count4}, 32'd0);
    chk("rst_in_ready",  {31'd0, in_ready4}, 32'd1);
    chk("rst_sel_err3",  {31'd0, sel_err3}, 32'd0);

    // Streaming sel 0..3; dut3 sees sel=3 as out of range.
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sel = 2'(i);
      tick();
      chk("strm_valid", {31'd0, out_valid4}, 32'd1);
      chk("strm_data",  out_data4, 32'h11111111 * (i + 1));
      chk("strm_count", {30'd0, count4}, 32'd1);
      chk("strm_ready", {31'd0, in_ready4}, 32'd1);
      chk("oor_data3",  out_data3, (i < 3) ? 32'h11111111 * (i + 1) : 32'd0);
      chk("oor_err3",   {31'd0, sel_err3}, (i == 3) ? 32'd1 : 32'd0);
    end
    sel = 2'd0;
    tick();
    chk("oor_next_err3",  {31'd0, sel_err3}, 32'd0);
    chk("oor_next_data3", out_data3, 32'h11111111);
    in_valid = 1'b0;
    tick();
    chk("drain_valid", {31'd0, out_valid4}, 32'd0);
    chk("drain_count", {30'd0, count4}, 32'd0);

    // Back-pressure: sel 2,3,1 with out_ready low.
    out_ready = 1'b0; in_valid = 1'b1; sel = 2'd2;
    tick();
    chk("bp1_count", {30'd0, count4}, 32'd1);
    chk("bp1_ready", {31'd0, in_ready4}, 32'd1);
    sel = 2'd3;
    tick();
    chk("bp2_count", {30'd0, count4}, 32'd2);
    chk("bp2_ready", {31'd0, in_ready4}, 32'd0);
    sel = 2'd1;
    tick();
    chk("bp3_count", {30'd0, count4}, 32'd2);
    chk("bp3_hold",  out_data4, 32'h33333333);
    chk("bp3_valid", {31'd0, out_valid4}, 32'd1);
    out_ready = 1'b1;
    tick();
    chk("bp4_data",  out_data4, 32'h44444444);
    chk("bp4_count", {30'd0, count4}, 32'd1);
    chk("bp4_ready", {31'd0, in_ready4}, 32'd1);
    chk("bp4_err3",  {31'd0, sel_err3}, 32'd1);
    tick();
    chk("bp5_data",  out_data4, 32'h22222222);
    chk("bp5_err3",  {31'd0, sel_err3}, 32'd0);
    in_valid = 1'b0;
    tick();
    chk("bp6_valid", {31'd0, out_valid4}, 32'd0);

    // Flush with full skid and an input offered.
    out_ready = 1'b0; in_valid = 1'b1; sel = 2'd0;
    tick();
    sel = 2'd1;
    tick();
    chk("fl_pre_count", {30'd0, count4}, 32'd2);
    flush = 1'b1; sel = 2'd2;
    tick();
    chk("fl_valid", {31'd0, out_valid4}, 32'd0);
    chk("fl_count", {30'd0, count4}, 32'd0);
    chk("fl_ready", {31'd0, in_ready4}, 32'd1);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick();
    chk("fl_after_valid", {31'd0, out_valid4}, 32'd0);
    in_valid = 1'b1; sel = 2'd3;
    tick();
    chk("fl_next_data", out_data4, 32'h44444444);
    chk("fl_next_count", {30'd0, count4}, 32'd1);
    in_valid = 1'b0;
    tick();

    // Reset beats flush and transfers with skid full.
    out_ready = 1'b0; in_valid = 1'b1; sel = 2'd1;
    tick();
    sel = 2'd2;
    tick();
    chk("rp_pre_count", {30'd0, count4}, 32'd2);
    rst = 1'b1; flush = 1'b1; out_ready = 1'b1;
    tick();
    chk("rp_valid", {31'd0, out_valid4}, 32'd0);
    chk("rp_data",  out_data4, 32'd0);
    chk("rp_count", {30'd0, count4}, 32'd0);
    chk("rp_ready", {31'd0, in_ready4}, 32'd1);
    chk("rp_data3", out_data3, 32'd0);
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
    tick();
    chk("rp_after_valid", {31'd0, out_valid4}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mux_pipe_stage.md
# mux_pipe_stage

Parametrised N-way datapath multiplexer with a registered, back-pressurable output stage. It is the pipelined successor to the plain 2:1 32-bit select used in the MIPS datapath. It selects one of INPUTS channels of WIDTH bits and passes the result through a 2-entry skid buffer with valid/ready handshakes. The block sits between pipeline stages, for example as a forwarding/operand select that must hold under stall and clear on flush.

## Interface
- WIDTH, 32, data width of each channel and of the output
- INPUTS, 4, number of input channels (≥2)
- SEL_W, $clog2(INPUTS), derived localparam, select width; not overridable
- clk  in  1  single clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- in_data  in  INPUTS*WIDTH  flattened channels; channel k at [k*WIDTH +: WIDTH]
- sel  in  SEL_W  channel index, sampled with in_data on input transfer
- in_valid  in  1  upstream offers in_data/sel
- in_ready  out  1  stage can accept this cycle
- out_data  out  WIDTH  selected, registered data
- out_valid  out  1  out_data is valid
- out_ready  in  1  downstream accepts this cycle
- sel_err  out  1  qualifies out_data: the captured sel was ≥ INPUTS
- flush  in  1  discard all held entries
- count  out  2  occupancy, 0..2

## Operation
- Input transfer: in_valid && in_ready at a rising edge. Output transfer: out_valid && out_ready at a rising edge.
- Selection on transfer: if sel < INPUTS, the captured data is channel sel. If sel ≥ INPUTS, the captured data is all-zeros and its sel_err flag is 1.
- Storage is two entries: main (drives out_*) and skid. Each entry holds data, err and valid.
- in_ready = !skid_valid. It is a register-derived signal with no combinational path from out_ready.
- Transfer rules, per edge, when not flushed:
  - Main empty, or main leaving via output transfer, with skid empty: the input (if any) loads into main.
  - Main full, not leaving, and input transfer occurs: the input loads into skid.
  - Skid full and main leaving: skid moves to main and skid empties. in_ready is 0 in that cycle, so no input is taken.
- Order is strict FIFO. No entry is reordered, dropped or duplicated.
- count = main_valid + skid_valid.
- flush (with rst low): at the edge, main_valid and skid_valid clear.
  - An input offered in the same cycle is dropped.
  - An output transfer in the same cycle counts as consumed; the data register content is don't-care.
  - Data registers keep their values.
- rst: both valids clear, data registers and err flags clear to 0. rst has priority over flush and over all transfers.
- Mid-operation reset: any held entries are lost, and the stage is empty after the edge.

## Timing
- Reset values after the first edge with rst high: out_valid=0, out_data=0, sel_err=0, count=0, in_ready=1.
- Latency is 1 cycle. Data accepted at edge N appears on out_data after edge N with out_valid=1.
- Throughput is 1 transfer/cycle while out_ready stays high. The skid stays empty in steady state.
- Stall:
  - First stalled cycle: one more input is absorbed into skid.
  - Next cycle: in_ready=0.
  - After out_ready rises: in_ready returns to 1 one cycle later.
- out_data, sel_err and out_valid are stable while out_valid && !out_ready (AXI-style hold).
- The in_ready and count changes caused by flush are visible the cycle after the flush edge.

## Test plan
- Reset: hold rst 2 cycles with in_valid=1 → out_valid=0, out_data=0, count=0, in_ready=1. The first accepted item appears only after rst falls.
- Streaming: INPUTS=4, channels {0x11111111, 0x22222222, 0x33333333, 0x44444444}, sel 0,1,2,3 on consecutive cycles with out_ready=1 → out_data is the same values in order, 1-cycle latency, count ≤1, in_ready always 1.
- Back-pressure: stream sel=2,3,1 while out_ready=0 from cycle 1 → count reaches 2 and in_ready=0 after the second accept. out_ready=1 → 0x33333333, 0x44444444, 0x22222222 emerge in order with none lost.
- Out-of-range: INPUTS=3, sel=3 → out_data=0, sel_err=1. The next item with sel=0 → sel_err=0.
- Flush: count=2, assert flush with in_valid=1 → next cycle out_valid=0, count=0, in_ready=1. The flushed and offered items never appear on the output.
- Reset priority: rst and flush together with a full skid and out_ready=1 → all outputs at reset values next cycle.
